// File: rtl/sd_sector_emu.sv
// RAM-backed stand-in for the user-side interface of an SD-card controller.
// Holds 2^SLOT_LOG2 sectors of 256 x 16-bit words and reproduces card-like
// timing: init delay, command latency, per-word spacing and a write busy tail.
module sd_sector_emu #(
    parameter int INIT_CYCLES = 1000,
    parameter int CMD_CYCLES  = 8,
    parameter int WORD_GAP    = 16,
    parameter int BUSY_TAIL   = 64,
    parameter int SLOT_LOG2   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        sd_init_done,
    input  logic        wr_start_en,
    input  logic [31:0] wr_sec_addr,
    output logic        wr_req,
    input  logic [15:0] wr_data,
    output logic        wr_busy,
    input  logic        rd_start_en,
    input  logic [31:0] rd_sec_addr,
    output logic        rd_val_en,
    output logic [15:0] rd_val_data,
    output logic        rd_busy
);

    // One shared delay counter serves INIT, the command phase and the write tail.
    localparam int DLY_MAX = (INIT_CYCLES > CMD_CYCLES)
                           ? ((INIT_CYCLES > BUSY_TAIL) ? INIT_CYCLES : BUSY_TAIL)
                           : ((CMD_CYCLES > BUSY_TAIL) ? CMD_CYCLES : BUSY_TAIL);
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int GAP_W   = $clog2(WORD_GAP);
    localparam int ADDR_W  = SLOT_LOG2 + 8;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_TAIL, S_RD_CMD, S_RD_DATA
    } state_t;

    state_t               state_q, state_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [8:0]           cnt_q, cnt_d;
    logic [SLOT_LOG2-1:0] slot_q, slot_d;
    logic                 init_done_q, init_done_d;
    logic                 wr_req_q, wr_req_d;
    logic                 wr_busy_q, wr_busy_d;
    logic                 rd_val_en_q, rd_val_en_d;
    logic                 rd_busy_q, rd_busy_d;
    logic [15:0]          rd_val_data_q;
    logic                 ram_we, ram_rd;
    logic [ADDR_W-1:0]    ram_addr;
    logic [15:0]          ram [DEPTH];

    // Upper sector-address bits are deliberately ignored (slot = low bits).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_sec_addr[31:SLOT_LOG2], rd_sec_addr[31:SLOT_LOG2]};

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        init_done_d = init_done_q;
        wr_req_d    = 1'b0;
        wr_busy_d   = wr_busy_q;
        rd_val_en_d = 1'b0;
        rd_busy_d   = rd_busy_q;
        ram_we      = 1'b0;
        ram_rd      = 1'b0;
        ram_addr    = {slot_q, cnt_q[7:0]};
        case (state_q)
            S_INIT: begin
                if (dly_q == DLY_W'(INIT_CYCLES)) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    dly_d       = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_IDLE: begin
                // Write has priority when both starts arrive together.
                if (wr_start_en) begin
                    state_d   = S_WR_CMD;
                    slot_d    = wr_sec_addr[SLOT_LOG2-1:0];
                    cnt_d     = '0;
                    dly_d     = '0;
                    wr_busy_d = 1'b1;
                end else if (rd_start_en) begin
                    state_d   = S_RD_CMD;
                    slot_d    = rd_sec_addr[SLOT_LOG2-1:0];
                    cnt_d     = '0;
                    dly_d     = '0;
                    rd_busy_d = 1'b1;
                end
            end
            S_WR_CMD: begin
                if (dly_q == DLY_W'(CMD_CYCLES - 1)) begin
                    state_d  = S_WR_DATA;
                    gap_d    = '0;
                    wr_req_d = 1'b1;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_WR_DATA: begin
                gap_d = (gap_q == GAP_W'(WORD_GAP - 1)) ? '0 : gap_q + GAP_W'(1);
                // The requested word is on wr_data one cycle after wr_req.
                if (gap_q == GAP_W'(1)) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q == 9'd255) begin
                        state_d = S_WR_TAIL;
                        dly_d   = '0;
                    end
                end
                if (gap_q == GAP_W'(WORD_GAP - 1) && state_d == S_WR_DATA) begin
                    wr_req_d = 1'b1;
                end
            end
            S_WR_TAIL: begin
                if (dly_q == DLY_W'(BUSY_TAIL - 1)) begin
                    state_d   = S_IDLE;
                    wr_busy_d = 1'b0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_RD_CMD: begin
                // Issue the first RAM read so its data lands with the first valid.
                if (dly_q == DLY_W'(CMD_CYCLES - 1)) begin
                    state_d     = S_RD_DATA;
                    gap_d       = '0;
                    ram_rd      = 1'b1;
                    rd_val_en_d = 1'b1;
                    cnt_d       = cnt_q + 9'd1;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            S_RD_DATA: begin
                gap_d = (gap_q == GAP_W'(WORD_GAP - 1)) ? '0 : gap_q + GAP_W'(1);
                if (rd_val_en_q && cnt_q == 9'd256) begin
                    state_d   = S_IDLE;
                    rd_busy_d = 1'b0;
                end else if (gap_q == GAP_W'(WORD_GAP - 1)) begin
                    ram_rd      = 1'b1;
                    rd_val_en_d = 1'b1;
                    cnt_d       = cnt_q + 9'd1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Control state and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            dly_q       <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            init_done_q <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_busy_q   <= 1'b0;
            rd_val_en_q <= 1'b0;
            rd_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            init_done_q <= init_done_d;
            wr_req_q    <= wr_req_d;
            wr_busy_q   <= wr_busy_d;
            rd_val_en_q <= rd_val_en_d;
            rd_busy_q   <= rd_busy_d;
        end
    end

    // Sector storage write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= wr_data;
        end
    end

    // Synchronous read port; the word is held until the next read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_val_data_q <= '0;
        end else if (ram_rd) begin
            rd_val_data_q <= ram[ram_addr];
        end
    end

    assign sd_init_done = init_done_q;
    assign wr_req       = wr_req_q;
    assign wr_busy      = wr_busy_q;
    assign rd_val_en    = rd_val_en_q;
    assign rd_val_data  = rd_val_data_q;
    assign rd_busy      = rd_busy_q;

endmodule

// File: tb/tb_sd_sector_emu.sv
// Scoreboard bench for sd_sector_emu: read data expected from a shadow copy of
// the sector RAM, plus timing checks on busy, request and valid strobes.
`timescale 1ns/1ps
module tb_sd_sector_emu;

    localparam int INIT_CYCLES = 20;
    localparam int CMD_CYCLES  = 3;
    localparam int WORD_GAP    = 4;
    localparam int BUSY_TAIL   = 5;
    localparam int SLOT_LOG2   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_init_done;
    logic        wr_start_en = 1'b0;
    logic [31:0] wr_sec_addr = '0;
    logic        wr_req;
    logic [15:0] wr_data = '0;
    logic        wr_busy;
    logic        rd_start_en = 1'b0;
    logic [31:0] rd_sec_addr = '0;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_busy;

    sd_sector_emu #(
        .INIT_CYCLES(INIT_CYCLES), .CMD_CYCLES(CMD_CYCLES), .WORD_GAP(WORD_GAP),
        .BUSY_TAIL(BUSY_TAIL), .SLOT_LOG2(SLOT_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done),
        .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_req(wr_req),
        .wr_data(wr_data), .wr_busy(wr_busy),
        .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .rd_val_en(rd_val_en),
        .rd_val_data(rd_val_data), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] model [0:1023];
    logic [15:0] exp_q [$];

    int   wr_cnt = 0, wr_first = 0, wr_last = 0, wr_rise = 0, wr_fall = 0, wr_rise_cnt = 0;
    int   rd_cnt = 0, rd_first = 0, rd_last = 0, rd_rise = 0, rd_fall = 0, rd_rise_cnt = 0;
    logic wr_busy_prev = 1'b0, rd_busy_prev = 1'b0;
    logic [15:0] src_base = '0;
    int   src_idx = 0;

    // Write data source: present the next word right after each request.
    always @(negedge clk) begin
        if (rst_n && wr_req) begin
            wr_data = src_base + 16'(src_idx);
            src_idx++;
        end
    end

    // Output monitor: strobe spacing, exclusivity, busy edges and scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_busy_prev = 1'b0;
            rd_busy_prev = 1'b0;
        end else begin
            chk("busy_excl", 32'(wr_busy & rd_busy), 0);
            chk("wr_req_outside", 32'(wr_req & ~wr_busy), 0);
            chk("rd_val_outside", 32'(rd_val_en & ~rd_busy), 0);
            if (wr_req) begin
                if (wr_cnt == 0) wr_first = cyc;
                else chk("wr_req_gap", cyc - wr_last, WORD_GAP);
                wr_last = cyc;
                wr_cnt++;
            end
            if (rd_val_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                else chk("rd_val_gap", cyc - rd_last, WORD_GAP);
                rd_last = cyc;
                rd_cnt++;
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", rd_val_data, exp_q.pop_front());
            end
            if (wr_busy && !wr_busy_prev) begin wr_rise = cyc; wr_rise_cnt++; end
            if (!wr_busy && wr_busy_prev) wr_fall = cyc;
            if (rd_busy && !rd_busy_prev) begin rd_rise = cyc; rd_rise_cnt++; end
            if (!rd_busy && rd_busy_prev) rd_fall = cyc;
            wr_busy_prev = wr_busy;
            rd_busy_prev = rd_busy;
        end
    end

    // Release reset and time the init phase; a write start during INIT must be dropped.
    task automatic do_init();
        int t, n, rise0;
        @(negedge clk);
        rst_n = 1'b1;
        t = cyc;
        rise0 = wr_rise_cnt;
        n = 0;
        while (!sd_init_done && n < INIT_CYCLES * 4) begin
            @(negedge clk);
            n++;
            if (n == 5) begin wr_start_en = 1'b1; wr_sec_addr = 32'd1; end
            if (n == 6) wr_start_en = 1'b0;
        end
        #1;
        chk("init_time", cyc - t, INIT_CYCLES + 1);
        repeat (3) @(negedge clk);
        #1;
        chk("init_nobusy", wr_rise_cnt - rise0, 0);
        chk("init_wr_busy", wr_busy, 0);
    endtask

    task automatic write_sector(input logic [31:0] addr, input logic [15:0] base, input bit both);
        int t, n, rd0, slot;
        wr_cnt   = 0;
        src_base = base;
        src_idx  = 0;
        rd0      = rd_rise_cnt;
        t        = cyc;
        wr_start_en = 1'b1;
        wr_sec_addr = addr;
        if (both) begin rd_start_en = 1'b1; rd_sec_addr = addr + 32'd1; end
        @(negedge clk);
        wr_start_en = 1'b0;
        rd_start_en = 1'b0;
        n = 0;
        while (wr_busy && n < 4000) begin
            @(negedge clk);
            n++;
            if (both && n == 40) begin rd_start_en = 1'b1; rd_sec_addr = addr; end
            if (both && n == 41) rd_start_en = 1'b0;
        end
        #1;
        chk("wr_done", wr_busy, 0);
        chk("wr_busy_rise", wr_rise, t + 1);
        chk("wr_first_req", wr_first, t + 1 + CMD_CYCLES);
        chk("wr_req_count", wr_cnt, 256);
        chk("wr_busy_fall", wr_fall, wr_last + 2 + BUSY_TAIL);
        if (both) chk("rd_ignored", rd_rise_cnt - rd0, 0);
        slot = int'(addr[SLOT_LOG2-1:0]);
        for (int i = 0; i < 256; i++) model[slot * 256 + i] = base + 16'(i);
    endtask

    task automatic read_sector(input logic [31:0] addr);
        int t, n, slot;
        slot = int'(addr[SLOT_LOG2-1:0]);
        for (int i = 0; i < 256; i++) exp_q.push_back(model[slot * 256 + i]);
        rd_cnt = 0;
        t = cyc;
        rd_start_en = 1'b1;
        rd_sec_addr = addr;
        @(negedge clk);
        rd_start_en = 1'b0;
        n = 0;
        while (rd_busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("rd_done", rd_busy, 0);
        chk("rd_busy_rise", rd_rise, t + 1);
        chk("rd_first_val", rd_first, t + 1 + CMD_CYCLES);
        chk("rd_val_count", rd_cnt, 256);
        chk("rd_busy_fall", rd_fall, rd_last + 1);
        chk("rd_queue_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_outs", {sd_init_done, wr_req, wr_busy, rd_val_en, rd_busy, rd_val_data}, 0);
        do_init();

        // Sector 20000 (slot 0) written with 0..255 and read back.
        write_sector(32'd20000, 16'h0000, 1'b0);
        read_sector(32'd20000);

        // Separate slots must not alias; address 4 maps onto slot 0.
        write_sector(32'd5, 16'h1000, 1'b0);
        read_sector(32'd5);
        read_sector(32'd4);

        // Simultaneous starts: write wins; a read start mid-write is dropped.
        write_sector(32'd2, 16'h2000, 1'b1);
        read_sector(32'd2);

        // Asynchronous reset in the middle of a write.
        wr_cnt = 0;
        src_base = 16'h4000;
        src_idx = 0;
        wr_start_en = 1'b1;
        wr_sec_addr = 32'd6;
        @(negedge clk);
        wr_start_en = 1'b0;
        n = 0;
        while (wr_cnt < 101 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reset_reach_word100", (wr_cnt >= 101) ? 1 : 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outs", {sd_init_done, wr_req, wr_busy, rd_val_en, rd_busy, rd_val_data}, 0);
        repeat (2) @(negedge clk);
        do_init();
        write_sector(32'd7, 16'h3000, 1'b0);
        read_sector(32'd7);
        chk("init_stays", sd_init_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
